eq_cfg_write_arbiter: RTL and testbench
=======================================

# eq_cfg_write_arbiter

Two-requester write controller that sequences configuration and band-gain updates into the equalizer register map (`reg_map`). Each accepted request is serialized into the map's byte-wide write port (`we`/`addr`/`data_in`), least-significant byte first, without interleaving between requesters. Requester A is the host command path and requester B is the preset/auto-gain loader; round-robin arbitration keeps either side from starving the other.

## Interface
- `GAIN_WIDTH`, 24: gain word width; fixed at 3 bytes, other values unsupported.
- `ADDR_WIDTH`, 31: width of the `reg_map` address bus.
- `NUM_BANDS`, 10: number of gain bands.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A holds a request.
- `a_ready`  out  1  A accepted this cycle when `a_valid & a_ready`.
- `a_band`  in  4  0 = configuration register; 1..10 = gain band.
- `a_data`  in  24  gain value; for band 0 only `[7:0]` is used.
- `b_valid`, `b_ready`, `b_band`, `b_data`: same as the A ports, for requester B.
- `we`  out  1  `reg_map` write strobe.
- `addr`  out  ADDR_WIDTH  `reg_map` byte address.
- `data_in`  out  8  `reg_map` write byte.
- `busy`  out  1  a write sequence is in progress.
- `err`  out  1  one-cycle pulse: accepted request had band > 10.

## Operation
- States are IDLE, WRITE and ERR.
- **IDLE**
  - Arbitrate between the two requesters. If only one valid is high, that requester wins. If both are high, the requester not served last wins.
  - The round-robin pointer resets to "B served last", so A wins the first tie.
  - Only the winner's ready is asserted. Ready is combinational from the valids, the state and the pointer. Both readies are 0 outside IDLE and while `rst` is high.
  - On acceptance, latch band and data, and update the pointer to the winner.
    - Band 0: next state WRITE with byte count 1.
    - Band 1..10: next state WRITE with byte count 3.
    - Band 11..15: next state ERR.
- **WRITE**
  - Emit one byte per cycle on consecutive cycles, with `we` high for each byte.
  - Band 0: `addr`=0, `data_in`=data[7:0].
  - Band b (1..10), byte k=0..2: `addr`=3b-2+k, `data_in`=data[8k+7:8k]. Band 10 therefore uses addresses 28, 29, 30.
  - After the last byte, go to IDLE.
- **ERR**
  - Pulse `err` high for one cycle with no write, then go to IDLE.
- `busy` is 1 in WRITE and ERR, 0 in IDLE.
- Latched band and data are isolated from the inputs. Requester inputs may change freely after acceptance without affecting the sequence in progress.
- Address arithmetic is 3*band-2+k, zero-extended to ADDR_WIDTH. It never wraps; the maximum address is 30.

## Timing
- Reset values: `we`=0, `addr`=0, `data_in`=0, `busy`=0, `err`=0, state IDLE, pointer "B served last", latches 0.
- All outputs except the readies are registered.
- A request is accepted at rising edge N.
  - Gain request: `we`=1 in cycles N+1, N+2 and N+3, and `busy`=1 in the same cycles. Ready can be high again in cycle N+4. Throughput is 4 cycles per gain write.
  - Configuration request: `we`=1 in cycle N+1 only. Next acceptance is possible in cycle N+2.
  - Invalid band: `err`=1 in cycle N+1 with `we`=0. Next acceptance is possible in cycle N+2.
- A sequence in progress is atomic. A request from the other requester arriving mid-sequence waits; it is granted in the first IDLE cycle.
- Valid held without ready: the request stays pending and data must be held stable by the requester (valid/ready convention). Deasserting valid before acceptance withdraws the request with no side effect.
- Reset mid-sequence:
  - Outputs, state and pointer return to reset values immediately (asynchronously).
  - The remaining bytes are dropped, so `reg_map` may hold a partially updated gain.
  - The requester re-issues the request after reset.
- Back-to-back requests from the same sole requester are served every 4 cycles, with no idle bubble beyond the IDLE acceptance cycle.

## Test plan
- **Single gain write.** Reset, then A sends band 2, 0x1C71C7. Required: `we` pulses on 3 consecutive cycles with addr/data 4/C7, 5/71, 6/1C. `reg_map` then reports gain_2 = 0x1C71C7.
- **Configuration write plus band 10.** A sends band 0, 0x0000AA; then B sends band 10, 0xFFFFFF. Required: one write 0/AA, followed by 28/FF, 29/FF, 30/FF. Configuration reads 0xAA and gain_10 reads 0xFFFFFF.
- **Round-robin under tie.** A and B both valid continuously with distinct bands (A: band 1, 0x123456; B: band 9, 0xE35A41). Required: grant order A, B, A, B; each 3-byte sequence is contiguous and never interleaved; acceptances are 4 cycles apart.
- **Invalid band.** A sends band 12. Required: `a_ready` handshake completes, `err`=1 for exactly one cycle, no `we` pulse, and `busy`=1 for that one cycle only.
- **Reset mid-sequence.** Assert `rst` between the first and second byte of band 5, 0x71AB1E. Required: `we`, `busy` and `addr` are 0 during reset with no further writes. After release, A's request is granted first when both requesters are valid.
- **Withdrawn and held requests.** B raises valid during A's sequence and drops it before IDLE. Required: B is never granted. A's inputs changing mid-sequence do not alter the emitted bytes.

Source files
------------

// File: rtl/eq_cfg_write_arbiter.sv
// Round-robin arbiter that serializes configuration and band-gain updates from
// two requesters into the equalizer register map's byte-wide write port.
module eq_cfg_write_arbiter #(
    parameter int GAIN_WIDTH = 24,
    parameter int ADDR_WIDTH = 31,
    parameter int NUM_BANDS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [3:0]            a_band,
    input  logic [GAIN_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [3:0]            b_band,
    input  logic [GAIN_WIDTH-1:0] b_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            data_in,
    output logic                  busy,
    output logic                  err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;
    localparam int NBYTES = GAIN_WIDTH / 8;

    logic [1:0]            r_state;
    logic                  r_last_b;
    logic [3:0]            r_band;
    logic [GAIN_WIDTH-1:0] r_data;
    logic [1:0]            r_idx;

    logic                  w_idle;
    logic                  w_sel_a;
    logic                  w_sel_b;
    logic [3:0]            w_band;
    logic [GAIN_WIDTH-1:0] w_data;
    logic                  w_band_ok;
    logic [5:0]            w_base;
    logic [1:0]            w_next_idx;
    logic                  w_last_byte;
    logic [7:0]            w_in_byte  [NBYTES];
    logic [7:0]            w_lat_byte [NBYTES];

    // On a tie the requester that was not served last wins.
    assign w_sel_a = a_valid && (!b_valid || r_last_b);
    assign w_sel_b = b_valid && (!a_valid || !r_last_b);
    assign w_idle  = (r_state == S_IDLE) && !rst;
    assign a_ready = w_idle && w_sel_a;
    assign b_ready = w_idle && w_sel_b;

    assign w_band    = w_sel_a ? a_band : b_band;
    assign w_data    = w_sel_a ? a_data : b_data;
    assign w_band_ok = ({28'd0, w_band} <= NUM_BANDS);
    // Band b's first byte lives at 3b-2; configuration register sits at 0.
    assign w_base    = (w_band == 4'd0) ? 6'd0
                     : ({1'b0, w_band, 1'b0} + {2'b00, w_band} - 6'd2);

    assign w_next_idx  = r_idx + 2'd1;
    assign w_last_byte = (r_band == 4'd0) || (r_idx == 2'(NBYTES - 1));

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign w_in_byte[gi]  = w_data[8*gi +: 8];
            assign w_lat_byte[gi] = r_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last_b <= 1'b1;
            r_band   <= '0;
            r_data   <= '0;
            r_idx    <= '0;
            we       <= 1'b0;
            addr     <= '0;
            data_in  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    we  <= 1'b0;
                    err <= 1'b0;
                    if (a_ready || b_ready) begin
                        r_last_b <= b_ready;
                        r_band   <= w_band;
                        r_data   <= w_data;
                        r_idx    <= '0;
                        busy     <= 1'b1;
                        if (w_band_ok) begin
                            r_state <= S_WRITE;
                            we      <= 1'b1;
                            addr    <= {{(ADDR_WIDTH-6){1'b0}}, w_base};
                            data_in <= w_in_byte[0];
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_byte) begin
                        r_state <= S_IDLE;
                        we      <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        r_idx   <= w_next_idx;
                        addr    <= addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        data_in <= w_lat_byte[w_next_idx];
                    end
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    we      <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_cfg_write_arbiter.sv
// Scoreboard bench for eq_cfg_write_arbiter: expected byte writes, error
// pulses and grant order are queued at each handshake and checked on output.
module tb_eq_cfg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [3:0]  a_band, b_band;
    logic [23:0] a_data, b_data;
    logic        we;
    logic [30:0] addr;
    logic [7:0]  data_in;
    logic        busy, err;

    eq_cfg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_band(a_band), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_band(b_band), .b_data(b_data),
        .we(we), .addr(addr), .data_in(data_in), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int waddr;
        int wdata;
    } wr_t;

    wr_t        wq[$];
    int         errq[$];
    int         grant_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;
    int         last_acc = -1;
    bit         gap_on = 1'b0;
    logic [7:0] mem [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference map: band b occupies bytes 3b-2..3b, LSB first, one per cycle.
    function automatic void push_req(input logic [3:0] band, input logic [23:0] data, input int c);
        if (band == 4'd0) begin
            wq.push_back('{c + 1, 0, int'(data[7:0])});
        end else if (band <= 4'd10) begin
            for (int k = 0; k < 3; k++)
                wq.push_back('{c + 1 + k, 3 * int'(band) - 2 + k, int'((data >> (8 * k)) & 24'hFF)});
        end else begin
            errq.push_back(c + 1);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (a_ready || b_ready) chk("ready_onehot", a_ready & b_ready, 0);
            if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                if (grant_q.size() == 0) chk("unexp_grant", {a_ready, b_ready}, 0);
                else chk("grant_who", b_ready, grant_q.pop_front());
                if (gap_on && last_acc >= 0) chk("accept_gap", cyc - last_acc, 4);
                last_acc = cyc;
                if (a_ready) push_req(a_band, a_data, cyc);
                else push_req(b_band, b_data, cyc);
            end
            if (we) begin
                chk("busy_we", busy, 1);
                mem[addr[4:0]] = data_in;
                if (wq.size() == 0) begin
                    chk("spurious_we", we, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_addr", addr, e.waddr);
                    chk("wr_data", data_in, e.wdata);
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                chk("missing_we", we, 1);
                void'(wq.pop_front());
            end
            if (err) begin
                chk("err_we", we, 0);
                chk("err_busy", busy, 1);
                if (errq.size() == 0) chk("spurious_err", err, 0);
                else chk("err_cyc", cyc, errq.pop_front());
            end else if (errq.size() > 0 && errq[0] <= cyc) begin
                chk("missing_err", err, 1);
                void'(errq.pop_front());
            end
        end
    end

    task automatic wait_hs(input int n);
        int got = 0;
        for (int i = 0; i < 60 && got < n; i++) begin
            @(negedge clk);
            if ((a_valid && a_ready) || (b_valid && b_ready)) got++;
        end
        if (got < n) chk("hs_timeout", got, n);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit who_b, input logic [3:0] band, input logic [23:0] data);
        grant_q.push_back(int'(who_b));
        if (!who_b) begin
            a_valid = 1'b1; a_band = band; a_data = data;
        end else begin
            b_valid = 1'b1; b_band = band; b_data = data;
        end
        wait_hs(1);
        if (!who_b) a_valid = 1'b0;
        else b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        rst = 1'b1;
        a_valid = 1'b1; a_band = '0; a_data = '0;
        b_valid = 1'b0; b_band = '0; b_data = '0;
        idle(3);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_a_ready", a_ready, 0);
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Single gain write
        send(1'b0, 4'd2, 24'h1C71C7);
        idle(5);
        chk("gain2", {mem[6], mem[5], mem[4]}, 24'h1C71C7);

        // Configuration write then band 10 from B
        send(1'b0, 4'd0, 24'h0000AA);
        send(1'b1, 4'd10, 24'hFFFFFF);
        idle(5);
        chk("cfg", mem[0], 8'hAA);
        chk("gain10", {mem[30], mem[29], mem[28]}, 24'hFFFFFF);

        // Round-robin under a continuous tie
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(0); grant_q.push_back(1);
        gap_on = 1'b1; last_acc = -1;
        a_valid = 1'b1; a_band = 4'd1; a_data = 24'h123456;
        b_valid = 1'b1; b_band = 4'd9; b_data = 24'hE35A41;
        wait_hs(4);
        a_valid = 1'b0; b_valid = 1'b0;
        gap_on = 1'b0;
        idle(6);
        chk("gain1", {mem[3], mem[2], mem[1]}, 24'h123456);
        chk("gain9", {mem[27], mem[26], mem[25]}, 24'hE35A41);

        // Invalid band
        send(1'b0, 4'd12, 24'h000000);
        @(negedge clk);
        chk("inv_busy1", busy, 1);
        @(negedge clk);
        chk("inv_busy0", busy, 0);
        chk("inv_err0", err, 0);
        idle(2);

        // Reset between first and second byte
        send(1'b0, 4'd5, 24'h71AB1E);
        @(negedge clk);
        #1;
        rst = 1'b1;
        wq.delete(); errq.delete(); grant_q.delete();
        a_valid = 1'b1; a_band = 4'd3; a_data = 24'hA1B2C3;
        b_valid = 1'b1; b_band = 4'd4; b_data = 24'h5D6E7F;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_we", we, 0);
        end
        chk("partial_byte1", mem[14], 8'h00);
        grant_q.push_back(0); grant_q.push_back(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_hs(2);
        a_valid = 1'b0; b_valid = 1'b0;
        idle(6);
        chk("gain3", {mem[9], mem[8], mem[7]}, 24'hA1B2C3);
        chk("gain4", {mem[12], mem[11], mem[10]}, 24'h5D6E7F);

        // Withdrawn B request, A inputs changing mid-sequence
        send(1'b0, 4'd7, 24'hC0FFEE);
        a_band = 4'hF; a_data = 24'h0BAD00;
        b_valid = 1'b1; b_band = 4'd2; b_data = 24'h111111;
        idle(1);
        a_data = 24'hFFFFFF;
        idle(1);
        b_valid = 1'b0;
        idle(6);
        chk("gain7", {mem[21], mem[20], mem[19]}, 24'hC0FFEE);
        chk("gain2_kept", {mem[6], mem[5], mem[4]}, 24'h1C71C7);

        idle(3);
        chk("drain_wr", wq.size(), 0);
        chk("drain_err", errq.size(), 0);
        chk("drain_grant", grant_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
